// File: rtl/exponential.sv
// ---------------------------------------------------------------------------
// exponential -- sequential 2^y for an unsigned fraction y in [0, 1).
//
// The result is built by multiplying an accumulator (format 1.m, starting at
// 1.0) by C(i) = 2^(2^-i) for every set bit y(i), one bit per clock, MSB
// first. After the last bit an extra cycle converts the accumulator to the
// output format and publishes it on x together with done=1.
//
// Parameters
//   n  fractional bits of result x
//   m  fractional bits of accumulator and constant ROM (m >= n)
//   p  fractional bits of operand y
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation, clears x
//   start  level request; accepted only in READY, so a held level never
//          retriggers (start must be seen low first)
//   y      operand 0.y(1)..y(p), registered on the accepting edge
//   x      result x(0).x(1)..x(n) in [1, 2), held until the next completion
//   done   high when idle and x is valid
//
// Build option
//   EXPONENTIAL_ROUND_EN  when defined, x is acc rounded to nearest at bit n
//                         (2.0 saturates to all ones); otherwise truncated.
// ---------------------------------------------------------------------------
module exponential #(
   parameter int n = 8,
   parameter int m = 16,
   parameter int p = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:p] y,
   output logic [0:n] x,
   output logic       done
);

   localparam int IW = $clog2(p + 1);

   localparam logic [1:0] WAIT_LOW = 2'd0;
   localparam logic [1:0] READY    = 2'd1;
   localparam logic [1:0] RUN      = 2'd2;

   localparam logic [m:0] ONE = {1'b1, {m{1'b0}}};

   // Constant ROM: entry k-1 holds 2^(2^-k) truncated to 1.m. The binary
   // expansion is extracted bit by bit so the width is not limited by an
   // integer conversion.
   function automatic logic [p*(m+1)-1:0] build_rom();
      logic [p*(m+1)-1:0] r;
      real e;
      real c;
      r = '0;
      for (int k = 1; k <= p; k++) begin
         e = 1.0;
         for (int j = 0; j < k; j++) e = e / 2.0;
         c = 2.0 ** e;
         for (int b = m; b >= 0; b--) begin
            if (c >= 1.0) begin
               r[(k-1)*(m+1) + b] = 1'b1;
               c = c - 1.0;
            end
            c = c * 2.0;
         end
      end
      return r;
   endfunction

   localparam logic [p*(m+1)-1:0] CROM = build_rom();

   // Full-width (m+1)x(m+1) product of two 1.m values, truncated back to 1.m.
   // Both factors are below 2 and the truncated partial products never reach
   // 2, so the top integer bit of the 2.2m product is always zero.
   function automatic logic [m:0] mul_trunc(input logic [m:0] a,
                                            input logic [m:0] c);
      logic [2*m+1:0] prod;
      prod = {{(m+1){1'b0}}, a} * {{(m+1){1'b0}}, c};
      return (m+1)'(prod >> m);
   endfunction

   // Accumulator (1.m) to output (1.n) conversion.
   function automatic logic [n:0] conv_out(input logic [m:0] a);
`ifdef EXPONENTIAL_ROUND_EN
      logic [n+2:0] s;
      // s = floor(a * 2^(n+1)) + 1, i.e. a + 2^-(n+1) in format 2.(n+1)
      s = (n+3)'({1'b0, a, 1'b0} >> (m - n)) + (n+3)'(1);
      if (s[n+2])
         return '1;
      else
         return (n+1)'(s >> 1);
`else
      return (n+1)'(a >> (m - n));
`endif
   endfunction

   logic [1:0]    state;
   logic [IW-1:0] i;
   logic          fin;
   logic [1:p]    y_r;
   logic [m:0]    acc;

   logic [IW-1:0] rom_idx;
   logic [m:0]    c_sel;
   logic [m:0]    acc_mul;

   always_comb begin
      rom_idx = i - IW'(1);
      c_sel   = CROM[rom_idx*(m+1) +: (m+1)];
      acc_mul = mul_trunc(acc, c_sel);
   end

   assign done = (state != RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= WAIT_LOW;
         i     <= IW'(1);
         fin   <= 1'b0;
         acc   <= ONE;
         x     <= '0;
      end else begin
         case (state)
            WAIT_LOW: begin
               if (!start) state <= READY;
            end
            READY: begin
               if (start) begin
                  state <= RUN;
                  y_r   <= y;
                  acc   <= ONE;
                  i     <= IW'(1);
                  fin   <= 1'b0;
               end
            end
            RUN: begin
               // fin marks the extra conversion cycle after bit p
               if (fin) begin
                  x     <= conv_out(acc);
                  fin   <= 1'b0;
                  state <= WAIT_LOW;
               end else begin
                  if (y_r[i]) acc <= acc_mul;
                  if (i == IW'(p))
                     fin <= 1'b1;
                  else
                     i <= i + IW'(1);
               end
            end
            default: state <= WAIT_LOW;
         endcase
      end
   end

endmodule

// File: tb/tb_exponential.sv
module tb_exponential;

   localparam int N = 8;
   localparam int M = 16;
   localparam int P = 16;
   localparam int LAT = P + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [P-1:0] y;
   logic [N:0]   x;
   logic         done;

   int tests = 0;
   int fails = 0;

   longint crom [1:P];

   typedef struct {
      logic [15:0] yv;
      logic [8:0]  xe;
   } vec_t;

   vec_t vecs [4];

   exponential #(.n(N), .m(M), .p(P)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .y     (y),
      .x     (x),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint got, input longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: 2^y as a product of 2^(2^-k) factors for each set bit,
   // each product truncated to 16 fractional bits, then converted.
   function automatic logic [8:0] model(input logic [15:0] yv);
      longint acc;
      longint r;
      acc = 64'd65536;
      for (int k = 1; k <= P; k++)
         if (yv[P-k]) acc = (acc * crom[k]) / 65536;
`ifdef EXPONENTIAL_ROUND_EN
      r = (acc + 128) / 256;
      if (r > 511) r = 511;
`else
      r = acc / 256;
`endif
      return r[8:0];
   endfunction

   // One operation: make sure start is seen low, request, then count the
   // cycles for which done is low (bounded).
   task automatic op(input logic [15:0] yv, input bit tog,
                     output logic [8:0] xr, output int low);
      start = 1'b0;
      tick();
      start = 1'b1;
      y = yv;
      tick();
      low = 0;
      while (done !== 1'b1 && low < 100) begin
         low++;
         if (tog) begin
            y = 16'($urandom);
            start = 1'($urandom_range(0, 1));
         end
         tick();
      end
      xr = x;
   endtask

   logic [8:0]  xr;
   logic [8:0]  xprev;
   logic [15:0] yv;
   int          low;

   initial begin
      for (int k = 1; k <= P; k++)
         crom[k] = longint'($floor((2.0 ** (1.0 / (2.0 ** k))) * 65536.0));

      vecs[0] = '{16'h0000, 9'h100};
      vecs[1] = '{16'h8000, 9'h16A};
      vecs[2] = '{16'h4000, 9'h130};
      vecs[3] = '{16'hFFFF, 9'h1FF};

      // Reset with start held high throughout and afterwards
      reset = 1'b1;
      start = 1'b1;
      y     = 16'h8000;
      tick();
      tick();
      check("reset_done", done, 1);
      check("reset_x", x, 0);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         check("held_start_idle", done, 1);
      end
      op(16'h0000, 1'b0, xr, low);
      check("first_op_latency", low, LAT);
      check("first_op_x", xr, 9'h100);

      // Spec vectors
      for (int v = 0; v < 4; v++) begin
         op(vecs[v].yv, 1'b0, xr, low);
         check("vec_x", xr, vecs[v].xe);
         check("vec_latency", low, LAT);
      end

      // start still high after completion: no retrigger
      for (int c = 0; c < 4; c++) tick();
      check("no_retrigger", done, 1);

      // x holds the previous result while an operation runs
      xprev = x;
      start = 1'b0;
      tick();
      start = 1'b1;
      y = 16'h0000;
      tick();
      tick();
      tick();
      check("x_hold_during_run", x, xprev);
      low = 0;
      while (done !== 1'b1 && low < 100) begin
         low++;
         tick();
      end
      check("x_hold_op_x", x, 9'h100);

      // Reset mid-RUN (8 cycles after acceptance)
      start = 1'b0;
      tick();
      start = 1'b1;
      y = 16'hFFFF;
      tick();
      for (int c = 0; c < 8; c++) tick();
      check("mid_run_busy", done, 0);
      reset = 1'b1;
      start = 1'b0;
      tick();
      reset = 1'b0;
      check("mid_reset_done", done, 1);
      check("mid_reset_x", x, 0);
      op(16'h8000, 1'b0, xr, low);
      check("after_reset_x", xr, 9'h16A);
      check("after_reset_latency", low, LAT);

      // Reset on the final RUN edge wins over the result load
      start = 1'b0;
      tick();
      start = 1'b1;
      y = 16'h4000;
      tick();
      for (int c = 0; c < LAT - 1; c++) tick();
      check("final_cycle_busy", done, 0);
      reset = 1'b1;
      start = 1'b0;
      tick();
      reset = 1'b0;
      check("final_reset_done", done, 1);
      check("final_reset_x", x, 0);

      // y and start toggled during RUN are ignored
      op(16'h4000, 1'b1, xr, low);
      check("toggle_x", xr, 9'h130);
      check("toggle_latency", low, LAT);
      op(16'h8000, 1'b1, xr, low);
      check("toggle2_x", xr, 9'h16A);

      // Randomized operands against the reference model
      for (int r = 0; r < 40; r++) begin
         yv = 16'($urandom);
         op(yv, (r % 4) == 3, xr, low);
         check("rand_x", xr, model(yv));
         check("rand_latency", low, LAT);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
